// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
package fifo_stream_pkg;

  localparam int unsigned BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;
  typedef logic [2:0] credit_t;

  // Free buffer slots once the word in flight and this cycle's pop are accounted for.
  function automatic credit_t credit_calc(input occ_t occ, input logic inflight, input logic pop);
    int c;
    c = int'(BUF_DEPTH) - int'(occ) - int'(inflight) + int'(pop);
    return (c > 0) ? credit_t'(c) : '0;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry register buffer; entry 0 is always the head presented downstream.
module skid_buf2
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_valid_o,
  output occ_t                  occ_o,
  output logic                  ovf_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  occ_t                  occ_q, occ_d;
  logic                  valid_q;
  logic                  do_pop;

  assign do_pop = pop_i && valid_q;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    ovf_o  = 1'b0;
    if (flush_i) begin
      occ_d = '0;
    end else begin
      case ({push_i, do_pop})
        2'b11: begin
          if (occ_q == 2'd2) begin
            ent0_d = ent1_q;
            ent1_d = push_data_i;
          end else begin
            ent0_d = push_data_i;
          end
        end
        2'b01: begin
          if (occ_q == 2'd2) ent0_d = ent1_q;
          occ_d = occ_q - 2'd1;
        end
        2'b10: begin
          case (occ_q)
            2'd0: begin
              ent0_d = push_data_i;
              occ_d  = 2'd1;
            end
            2'd1: begin
              ent1_d = push_data_i;
              occ_d  = 2'd2;
            end
            default: ovf_o = 1'b1; // word dropped
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      occ_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      occ_q   <= occ_d;
      valid_q <= (occ_d != '0);
    end
  end

  assign head_data_o  = ent0_q;
  assign head_valid_o = valid_q;
  assign occ_o        = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for myFIFO: credit-based rd_en, latency-matched capture,
// and a 2-entry buffer presenting a full-rate valid/ready stream.
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          FWFT_EN    = 1'b0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  err_ovf
);

  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 err_ovf_q, err_ovf_d;
  logic                 pop, push, ovf;
  occ_t                 occ;

  assign pop        = m_valid && m_ready;
  assign fifo_rd_en = rstn && !flush && !fifo_empty && (credit_calc(occ, inflight_q, pop) != '0);

  // Standard FIFOs return data a cycle after rd_en; FWFT data is already on dout.
  assign inflight_d = FWFT_EN ? 1'b0 : fifo_rd_en;
  assign push       = FWFT_EN ? fifo_rd_en : inflight_q;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_ovf_d  = err_ovf_q || ovf;
    if (pop) beat_cnt_d = beat_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .push_i       (push),
    .push_data_i  (fifo_dout),
    .pop_i        (pop),
    .flush_i      (flush),
    .head_data_o  (m_data),
    .head_valid_o (m_valid),
    .occ_o        (occ),
    .ovf_o        (ovf)
  );

  assign occupancy = occ;
  assign beat_cnt  = beat_cnt_q;
  assign err_ovf   = err_ovf_q;

endmodule
